mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction and data caches share one memory port
// with a single outstanding transaction and fixed read latency MEM_LAT.
module mem_arbiter #(
   parameter int MEM_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req,
   input  logic [15:0]      i_addr,
   output logic             i_gnt,
   output logic             i_done,
   output logic [15:0]      i_rdata,
   input  logic             d_req,
   input  logic             d_wr,
   input  logic [15:0]      d_addr,
   input  logic [15:0]      d_wdata,
   output logic             d_gnt,
   output logic             d_done,
   output logic [15:0]      d_rdata,
   output logic             m_en,
   output logic             m_wr,
   output logic [15:0]      m_addr,
   output logic [15:0]      m_wdata,
   input  logic [15:0]      m_rdata,
   output logic [CNT_W-1:0] i_cnt,
   output logic [CNT_W-1:0] d_cnt,
   output logic [CNT_W-1:0] conflict_cnt
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t      state, nextState;
   logic        lastSrvD;
   logic [3:0]  latCnt;
   logic [15:0] latAddr, latWdata;
   logic        latWr;
   logic        iWin, dWin, doneNow, bothReq;

   // Winner selection: on a conflict the side not served last wins.
   always_comb begin
      iWin    = 1'b0;
      dWin    = 1'b0;
      bothReq = i_req && d_req;
      if (state == IDLE) begin
         if (bothReq) begin
            dWin = !lastSrvD;
            iWin = lastSrvD;
         end else begin
            iWin = i_req;
            dWin = d_req;
         end
      end
      doneNow = (state != IDLE) && (latCnt == 4'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (dWin) nextState = D_BUSY;
                  else if (iWin) nextState = I_BUSY;
         I_BUSY,
         D_BUSY:  if (doneNow) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Outputs are forced low while reset is held, even though req inputs
   // would otherwise produce a combinational grant in IDLE.
   always_comb begin
      i_gnt   = 1'b0;
      d_gnt   = 1'b0;
      i_done  = 1'b0;
      d_done  = 1'b0;
      i_rdata = '0;
      d_rdata = '0;
      m_en    = 1'b0;
      m_wr    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               i_gnt = iWin;
               d_gnt = dWin;
               if (iWin) begin
                  m_en   = 1'b1;
                  m_addr = i_addr;
               end else if (dWin) begin
                  m_en    = 1'b1;
                  m_addr  = d_addr;
                  m_wr    = d_wr;
                  m_wdata = d_wdata;
               end
            end
            I_BUSY: begin
               m_addr  = latAddr;
               m_wr    = latWr;
               m_wdata = latWdata;
               i_done  = doneNow;
               if (doneNow) i_rdata = m_rdata;
            end
            D_BUSY: begin
               m_addr  = latAddr;
               m_wr    = latWr;
               m_wdata = latWdata;
               d_done  = doneNow;
               if (doneNow && !latWr) d_rdata = m_rdata;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastSrvD <= 1'b0;
         latCnt   <= '0;
         latAddr  <= '0;
         latWdata <= '0;
         latWr    <= 1'b0;
      end else if (state == IDLE) begin
         if (iWin) begin
            latAddr  <= i_addr;
            latWr    <= 1'b0;
            latWdata <= '0;
            latCnt   <= 4'(MEM_LAT);
         end else if (dWin) begin
            latAddr  <= d_addr;
            latWr    <= d_wr;
            latWdata <= d_wdata;
            latCnt   <= 4'(MEM_LAT);
         end
      end else begin
         latCnt <= latCnt - 4'd1;
         if (doneNow) lastSrvD <= (state == D_BUSY);
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_cnt        <= '0;
         d_cnt        <= '0;
         conflict_cnt <= '0;
      end else begin
         if (iWin && i_cnt != CNT_MAX) i_cnt <= i_cnt + CNT_W'(1);
         if (dWin && d_cnt != CNT_MAX) d_cnt <= d_cnt + CNT_W'(1);
         if (state == IDLE && bothReq && conflict_cnt != CNT_MAX)
            conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model that
// tracks the busy window, owner and fairness flag as plain integers.
module tb_mem_arbiter;

   localparam int LAT  = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
   logic [15:0]   i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
   logic          i_gnt, i_done, d_gnt, d_done, m_en, m_wr;
   logic [15:0]   i_rdata, d_rdata, m_addr, m_wdata;
   logic [CW-1:0] i_cnt, d_cnt, conflict_cnt;

   int nVec = 0, nErr = 0;

   // reference model state
   bit          mBusy, mOwnD, mLastD, latW;
   int          mDoneAt, cycNo, cntI, cntD, cntC;
   logic [15:0] latA, latWd;

   mem_arbiter #(.MEM_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
      .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .i_cnt(i_cnt), .d_cnt(d_cnt), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mBusy = 0; mOwnD = 0; mLastD = 0; latW = 0;
      mDoneAt = -1; cntI = 0; cntD = 0; cntC = 0;
      latA = '0; latWd = '0;
   endtask

   // Predict this cycle's outputs, compare, then advance across the next edge.
   task automatic evalModel();
      logic eIg, eDg, eMen, eW, eId, eDd;
      logic [15:0] eA, eWd, eIr, eDr;
      eIg = 0; eDg = 0; eMen = 0; eW = 0; eId = 0; eDd = 0;
      eA = '0; eWd = '0; eIr = '0; eDr = '0;
      if (!mBusy) begin
         if (i_req && d_req) begin eDg = !mLastD; eIg = mLastD; end
         else begin eIg = i_req; eDg = d_req; end
         eMen = eIg | eDg;
         if (eIg) eA = i_addr;
         if (eDg) begin eA = d_addr; eW = d_wr; eWd = d_wdata; end
      end else begin
         eA = latA; eW = latW; eWd = latWd;
         if (cycNo == mDoneAt) begin
            if (mOwnD) begin eDd = 1; eDr = latW ? 16'h0 : m_rdata; end
            else begin eId = 1; eIr = m_rdata; end
         end
      end
      chk("i_gnt", 32'(i_gnt), 32'(eIg));
      chk("d_gnt", 32'(d_gnt), 32'(eDg));
      chk("m_en", 32'(m_en), 32'(eMen));
      chk("i_done", 32'(i_done), 32'(eId));
      chk("d_done", 32'(d_done), 32'(eDd));
      chk("i_rdata", 32'(i_rdata), 32'(eIr));
      chk("d_rdata", 32'(d_rdata), 32'(eDr));
      chk("i_cnt", 32'(i_cnt), 32'(cntI));
      chk("d_cnt", 32'(d_cnt), 32'(cntD));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(cntC));
      if (eMen || mBusy) begin
         chk("m_addr", 32'(m_addr), 32'(eA));
         chk("m_wr", 32'(m_wr), 32'(eW));
         chk("m_wdata", 32'(m_wdata), 32'(eWd));
      end
      if (!mBusy && i_req && d_req && cntC < CMAX) cntC++;
      if (eIg && cntI < CMAX) cntI++;
      if (eDg && cntD < CMAX) cntD++;
      if (mBusy && cycNo == mDoneAt) begin
         mBusy = 0; mLastD = mOwnD;
      end else if (eMen) begin
         mBusy = 1; mOwnD = eDg; mDoneAt = cycNo + LAT;
         latA = eA; latW = eW; latWd = eWd;
      end
      cycNo++;
   endtask

   task automatic cyc(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                      input logic [15:0] da, input logic [15:0] dwd);
      @(posedge clk); #1;
      i_req = ir; i_addr = ia; d_req = dr; d_wr = dw; d_addr = da; d_wdata = dwd;
      m_rdata = 16'($urandom);
      @(negedge clk);
      evalModel();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop at once.
   task automatic doReset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ctl", 32'({i_gnt, d_gnt, m_en, m_wr, i_done, d_done}), 32'h0);
      chk("rst_m", {m_addr, m_wdata}, 32'h0);
      chk("rst_rdata", {i_rdata, d_rdata}, 32'h0);
      chk("rst_cnt", 32'({i_cnt, d_cnt, conflict_cnt}), 32'h0);
      i_req = 1'b1; d_req = 1'b1;
      @(negedge clk);
      chk("rst_gnt", 32'({i_gnt, d_gnt, m_en}), 32'h0);
      @(posedge clk); #1;
      i_req = 0; d_req = 0; d_wr = 0;
      rst_n = 1'b1;
      modelReset();
   endtask

   initial begin
      cycNo = 0;
      modelReset();
      doReset();

      // lone instruction fetch
      for (int k = 0; k < 5; k++) cyc(1, 16'h0040, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("lone_i_cnt", 32'(i_cnt), 32'd1);

      // first conflict after reset goes to D, then I
      doReset();
      for (int k = 0; k < 5; k++) cyc(1, 16'h0100, 1, 0, 16'h0200, 16'h0);
      for (int k = 0; k < 5; k++) cyc(1, 16'h0100, 0, 0, 16'h0200, 16'h0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("conf1_cnt", 32'(conflict_cnt), 32'd1);
      chk("conf1_icnt", 32'(i_cnt), 32'd1);

      // continuous contention alternates D,I,D,I
      doReset();
      for (int k = 0; k < 20; k++) cyc(1, 16'h0300, 1, 0, 16'h0400, 16'h0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("alt_icnt", 32'(i_cnt), 32'd2);
      chk("alt_dcnt", 32'(d_cnt), 32'd2);

      // data write holds address/data through the busy window
      for (int k = 0; k < 5; k++) cyc(0, 0, 1, 1, 16'h1000, 16'hBEEF);
      cyc(0, 0, 0, 0, 0, 0);

      // reset interrupts an instruction transaction
      cyc(1, 16'h0500, 0, 0, 0, 0);
      cyc(1, 16'h0500, 0, 0, 0, 0);
      cyc(1, 16'h0500, 0, 0, 0, 0);
      doReset();
      for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 0);

      // counter saturation: 17 lone grants
      for (int k = 0; k < 85; k++) cyc(1, 16'h0600, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("sat_icnt", 32'(i_cnt), 32'(CMAX));

      // random traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) doReset();
         cyc(1'($urandom_range(0, 1)), 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom), 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
